oddr_serializer: RTL and testbench

//  Transmit-side counterpart of the IDDRE1 input DDR capture model.

---
 rtl/oddr_pkg.sv | 44 ++++
 rtl/oddr_serializer_if.sv | 15 +
 rtl/oddr_out_stage.sv | 49 ++++
 rtl/oddr_serializer.sv | 90 +++++++++
 tb/tb_oddr_serializer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/oddr_pkg.sv
// Shared helpers for the ODDR serializer and its future deserializer twin:
// word/pair sizing and the bit-order convention for pairs.
package oddr_pkg;

   localparam int MAX_W = 64;
   localparam int IDX_W = $clog2(MAX_W);

   typedef struct packed {
      logic first;   // shown while C is high
      logic second;  // shown while C is low
   } pair_t;

   function automatic int np(input int width);
      return width / 2;
   endfunction

   function automatic int cnt_w(input int width);
      return (np(width) > 1) ? $clog2(np(width)) : 1;
   endfunction

   // Pair idx of a width-bit word, in the order it goes on the wire.
   function automatic pair_t pair_sel(input logic [MAX_W-1:0] w, input int width,
                                      input int idx, input bit lsb_first);
      logic [IDX_W-1:0] i0;
      logic [IDX_W-1:0] i1;
      pair_t            p;
      if (lsb_first) begin
         i0 = IDX_W'(2 * idx);
         i1 = IDX_W'(2 * idx + 1);
      end else begin
         i0 = IDX_W'(width - 1 - 2 * idx);
         i1 = IDX_W'(width - 2 - 2 * idx);
      end
      p.first  = w[i0];
      p.second = w[i1];
      return p;
   endfunction

   // Drops pair 0 so the next pair to send sits where pair_sel(.., 0, ..) looks.
   function automatic logic [MAX_W-1:0] pair_shift(input logic [MAX_W-1:0] w, input bit lsb_first);
      return lsb_first ? (w >> 2) : (w << 2);
   endfunction

endpackage

// File: rtl/oddr_serializer_if.sv
// Word handshake plus DDR pad-side outputs of the serializer.
interface oddr_serializer_if #(parameter int DATA_WIDTH = 8);

   logic [DATA_WIDTH-1:0] S_DATA;
   logic                  S_VALID;
   logic                  S_READY;
   logic                  Q;
   logic                  T;
   logic                  FRAME;
   logic                  BUSY;

   modport master (output S_DATA, S_VALID, input S_READY, Q, T, FRAME, BUSY);
   modport slave  (input S_DATA, S_VALID, output S_READY, Q, T, FRAME, BUSY);

endinterface

// File: rtl/oddr_out_stage.sv
// ODDRE1-like output stage: two data registers and a tristate register,
// with Q muxed by the level of C (same-edge launch of both bits).
module oddr_out_stage
   import oddr_pkg::*;
#(
   parameter logic SRVAL         = 1'b0,
   parameter logic IDLE_VAL      = 1'b0,
   parameter bit   TRISTATE_IDLE = 1'b1
) (
   input  logic  c_i,
   input  logic  r_ni,
   input  logic  load_i,
   input  pair_t pair_i,
   output logic  q_o,
   output logic  t_o
);

   logic d1_q, d1_d;
   logic d2_q, d2_d;
   logic t_q, t_d;

   always_comb begin
      d1_d = IDLE_VAL;
      d2_d = IDLE_VAL;
      t_d  = TRISTATE_IDLE;
      if (load_i) begin
         d1_d = pair_i.first;
         d2_d = pair_i.second;
         t_d  = 1'b0;
      end
   end

   always_ff @(posedge c_i) begin
      if (!r_ni) begin
         d1_q <= SRVAL;
         d2_q <= SRVAL;
         t_q  <= TRISTATE_IDLE;
      end else begin
         d1_q <= d1_d;
         d2_q <= d2_d;
         t_q  <= t_d;
      end
   end

   // Glitch-free by construction only if d1/d2 settle well inside the high phase.
   assign q_o = c_i ? d1_q : d2_q;
   assign t_o = t_q;

endmodule

// File: rtl/oddr_serializer.sv
// Parallel-to-DDR serializer: accepts a word over valid/ready and sends it
// two bits per C cycle, back-to-back words with no bubble.
module oddr_serializer
   import oddr_pkg::*;
#(
   parameter int   DATA_WIDTH    = 8,
   parameter int   LSB_FIRST     = 1,
   parameter logic SRVAL         = 1'b0,
   parameter logic IDLE_VAL      = 1'b0,
   parameter int   TRISTATE_IDLE = 1
) (
   input  logic               C,
   input  logic               R,
   oddr_serializer_if.slave   bus
);

   localparam int NP  = np(DATA_WIDTH);
   localparam int CW  = cnt_w(DATA_WIDTH);
   localparam bit LSB = (LSB_FIRST != 0);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  frame_q, frame_d;
   logic                  busy_q, busy_d;
   logic                  ready, xfer, load;
   pair_t                 pair;
   logic [MAX_W-1:0]      word_ext, sh_ext;

   assign word_ext = MAX_W'(bus.S_DATA);
   assign sh_ext   = MAX_W'(sh_q);

   // Ready as soon as the last queued pair is on the wire, which is what makes streaming gapless.
   assign ready = R & (cnt_q == '0);
   assign xfer  = bus.S_VALID & ready;

   always_comb begin
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      frame_d = 1'b0;
      busy_d  = 1'b0;
      load    = 1'b0;
      pair    = '0;
      if (xfer) begin
         pair    = pair_sel(word_ext, DATA_WIDTH, 0, LSB);
         sh_d    = DATA_WIDTH'(pair_shift(word_ext, LSB));
         cnt_d   = CW'(NP - 1);
         frame_d = 1'b1;
         busy_d  = 1'b1;
         load    = 1'b1;
      end else if (cnt_q != '0) begin
         pair    = pair_sel(sh_ext, DATA_WIDTH, 0, LSB);
         sh_d    = DATA_WIDTH'(pair_shift(sh_ext, LSB));
         cnt_d   = cnt_q - CW'(1);
         busy_d  = 1'b1;
         load    = 1'b1;
      end
   end

   always_ff @(posedge C) begin
      if (!R) begin
         cnt_q   <= '0;
         sh_q    <= '0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
      end
   end

   oddr_out_stage #(
      .SRVAL         (SRVAL),
      .IDLE_VAL      (IDLE_VAL),
      .TRISTATE_IDLE (TRISTATE_IDLE != 0)
   ) u_out (
      .c_i    (C),
      .r_ni   (R),
      .load_i (load),
      .pair_i (pair),
      .q_o    (bus.Q),
      .t_o    (bus.T)
   );

   assign bus.S_READY = ready;
   assign bus.FRAME   = frame_q;
   assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Three serializer configurations driven side by side; a word-level model
// predicts every half-cycle of Q and the per-cycle status outputs.
module tb_oddr_serializer;

   localparam int PW[3] = '{8, 8, 2};
   localparam bit PL[3] = '{1'b1, 1'b0, 1'b1};
   localparam bit PS[3] = '{1'b1, 1'b0, 1'b0};
   localparam bit PI[3] = '{1'b0, 1'b1, 1'b0};
   localparam bit PT[3] = '{1'b1, 1'b0, 1'b1};

   logic       C = 1'b0;
   logic       R;
   logic [7:0] din[3];
   logic       vin[3];

   int checks = 0;
   int errors = 0;

   oddr_serializer_if #(.DATA_WIDTH(8)) if0 ();
   oddr_serializer_if #(.DATA_WIDTH(8)) if1 ();
   oddr_serializer_if #(.DATA_WIDTH(2)) if2 ();

   assign if0.S_DATA  = din[0];
   assign if1.S_DATA  = din[1];
   assign if2.S_DATA  = din[2][1:0];
   assign if0.S_VALID = vin[0];
   assign if1.S_VALID = vin[1];
   assign if2.S_VALID = vin[2];

   oddr_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1), .SRVAL(1'b1), .IDLE_VAL(1'b0), .TRISTATE_IDLE(1))
      u_dut0 (.C(C), .R(R), .bus(if0));
   oddr_serializer #(.DATA_WIDTH(8), .LSB_FIRST(0), .SRVAL(1'b0), .IDLE_VAL(1'b1), .TRISTATE_IDLE(0))
      u_dut1 (.C(C), .R(R), .bus(if1));
   oddr_serializer #(.DATA_WIDTH(2), .LSB_FIRST(1), .SRVAL(1'b0), .IDLE_VAL(1'b0), .TRISTATE_IDLE(1))
      u_dut2 (.C(C), .R(R), .bus(if2));

   logic [2:0] qo, to, fo, bo, ro;
   assign qo = {if2.Q, if1.Q, if0.Q};
   assign to = {if2.T, if1.T, if0.T};
   assign fo = {if2.FRAME, if1.FRAME, if0.FRAME};
   assign bo = {if2.BUSY, if1.BUSY, if0.BUSY};
   assign ro = {if2.S_READY, if1.S_READY, if0.S_READY};

   always #5 C = ~C;

   // Model state: pairs of the word in flight, in wire order.
   logic [1:0] pr[3][4];
   int         nx[3];
   int         left[3];
   bit         acc[3];
   logic       e1[3], e2[3], et[3], ef[3], eb[3];
   logic       hi_q[3];

   // Histories, newest entry in the low bits.
   logic [31:0] qlog[3];
   logic [15:0] flog[3], rlog[3], blog[3], tlog[3];

   task automatic chk(input string nm, input int i, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got %b want %b", nm, i, $time, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, act, exp);
      end
   endtask

   task automatic model_step(input int i);
      logic b[8];
      acc[i] = 1'b0;
      if (!R) begin
         left[i] = 0;
         e1[i] = PS[i]; e2[i] = PS[i]; et[i] = PT[i]; ef[i] = 1'b0; eb[i] = 1'b0;
      end else if (vin[i] && left[i] == 0) begin
         for (int k = 0; k < PW[i]; k++)
            b[k] = PL[i] ? din[i][k] : din[i][PW[i]-1-k];
         for (int p = 0; p < PW[i] / 2; p++)
            pr[i][p] = {b[2*p], b[2*p+1]};
         acc[i]  = 1'b1;
         nx[i]   = 1;
         left[i] = PW[i] / 2 - 1;
         e1[i] = b[0]; e2[i] = b[1]; et[i] = 1'b0; ef[i] = 1'b1; eb[i] = 1'b1;
      end else if (left[i] > 0) begin
         {e1[i], e2[i]} = pr[i][nx[i]];
         nx[i]++;
         left[i]--;
         et[i] = 1'b0; ef[i] = 1'b0; eb[i] = 1'b1;
      end else begin
         e1[i] = PI[i]; e2[i] = PI[i]; et[i] = PT[i]; ef[i] = 1'b0; eb[i] = 1'b0;
      end
   endtask

   always @(posedge C) begin
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         hi_q[i] = qo[i];
         chk("q_high", i, qo[i], e1[i]);
         chk("t_high", i, to[i], et[i]);
         chk("frame", i, fo[i], ef[i]);
         chk("busy", i, bo[i], eb[i]);
      end
      @(negedge C);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("q_low", i, qo[i], e2[i]);
         chk("t_low", i, to[i], et[i]);
         chk("ready", i, ro[i], R && (left[i] == 0));
         qlog[i] = {qlog[i][29:0], hi_q[i], qo[i]};
         flog[i] = {flog[i][14:0], fo[i]};
         rlog[i] = {rlog[i][14:0], ro[i]};
         blog[i] = {blog[i][14:0], bo[i]};
         tlog[i] = {tlog[i][14:0], to[i]};
      end
   end

   // Inputs change 7 time units after each posedge, away from both edges.
   task automatic wc(input int n);
      repeat (n) @(posedge C);
      #7;
   endtask

   initial begin
      R = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din[i] = '0; vin[i] = 1'b0; left[i] = 0; nx[i] = 0; acc[i] = 1'b0;
         qlog[i] = '0; flog[i] = '0; rlog[i] = '0; blog[i] = '0; tlog[i] = '0;
      end

      // Reset, then two idle cycles.
      wc(2);
      R = 1'b1;
      wc(2);
      chkv("rst_idle_q0", qlog[0][7:0], 8'b11110000);
      chkv("rst_idle_q1", qlog[1][7:0], 8'b00001111);
      chkv("rst_idle_t0", tlog[0][3:0], 4'b1111);
      chkv("rst_idle_t1", tlog[1][3:0], 4'b0000);
      chkv("rst_idle_rdy", rlog[0][3:0], 4'b0011);
      chkv("rst_idle_frame", flog[0][3:0], 4'b0000);

      // Single word, LSB first.
      vin[0] = 1'b1; din[0] = 8'hA5;
      wc(1);
      vin[0] = 1'b0;
      wc(3);
      chkv("a5_q", qlog[0][7:0], 8'b10100101);
      chkv("a5_frame", flog[0][3:0], 4'b1000);
      chkv("a5_t", tlog[0][3:0], 4'b0000);
      chkv("a5_busy", blog[0][3:0], 4'b1111);

      // Back-to-back words with S_VALID held.
      vin[0] = 1'b1; din[0] = 8'hA5;
      wc(1);
      din[0] = 8'h3C;
      wc(4);
      vin[0] = 1'b0;
      wc(3);
      chkv("b2b_q", qlog[0][15:0], 16'b1010010100111100);
      chkv("b2b_ready", rlog[0][7:0], 8'b00010001);
      chkv("b2b_frame", flog[0][7:0], 8'b10001000);

      // MSB first.
      vin[1] = 1'b1; din[1] = 8'h80;
      wc(1);
      vin[1] = 1'b0;
      wc(3);
      chkv("msb80_q", qlog[1][7:0], 8'b10000000);
      wc(1);
      chkv("msb80_idle", qlog[1][1:0], 2'b11);

      // Reset in the middle of a word.
      vin[0] = 1'b1; din[0] = 8'hFF;
      wc(1);
      vin[0] = 1'b0;
      wc(1);
      R = 1'b0;
      wc(1);
      chkv("rstmid_q", qlog[0][1:0], 2'b11);
      chkv("rstmid_busy", blog[0][0], 1'b0);
      chkv("rstmid_t", tlog[0][0], 1'b1);
      chkv("rstmid_rdy", rlog[0][0], 1'b0);
      R = 1'b1;
      wc(2);
      chkv("rstmid_after_q", qlog[0][9:0], 10'b1111110000);
      chkv("rstmid_after_busy", blog[0][1:0], 2'b00);
      chkv("rstmid_after_rdy", rlog[0][1:0], 2'b11);

      // Two-bit words streamed.
      vin[2] = 1'b1; din[2] = 8'h01;
      wc(1);
      din[2] = 8'h02;
      wc(1);
      vin[2] = 1'b0;
      chkv("w2_q", qlog[2][3:0], 4'b1001);
      chkv("w2_ready", rlog[2][1:0], 2'b11);

      // Random traffic with occasional resets; data held while stalled.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!vin[i] || acc[i]) begin
               vin[i] = ($urandom_range(0, 3) != 0);
               din[i] = 8'($urandom);
            end
         end
         R = ($urandom_range(0, 60) != 0);
         wc(1);
      end
      R = 1'b1;
      for (int i = 0; i < 3; i++) vin[i] = 1'b0;
      wc(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
